// File: rtl/demux_dispatch_pkg.sv
// rtl/demux_dispatch_pkg.sv - shared constants, state encoding and pointer helper for demux_dispatch
package demux_dispatch_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        BURST = 2'd2
    } state_t;

    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] sel);
        return sel + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational 4-way round-robin picker starting at ptr
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] grant_idx,
    output logic       any_grant
);

    // Scan offsets from farthest to nearest so the closest request to ptr wins.
    always_comb begin
        grant_idx = ptr;
        any_grant = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (req[2'(ptr + 2'(i))]) begin
                grant_idx = 2'(ptr + 2'(i));
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_dispatch.sv
// rtl/demux_dispatch.sv - round-robin burst dispatcher driving a 1-to-4 demux data and select
module demux_dispatch
    import demux_dispatch_pkg::*;
#(
    parameter int DATA_W    = 1,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [3:0]        ch_en,
    input  logic [3:0]        ch_ready,
    output logic [DATA_W-1:0] dmx_in,
    output logic [1:0]        dmx_sel,
    output logic              dmx_valid,
    output logic              burst_done
);

    localparam int               CNT_W    = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    state_t            state;
    state_t            state_nxt;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  sel_q;
    logic [CNT_W-1:0]  beat_cnt;
    logic [3:0]        cand;
    logic [1:0]        win_idx;
    logic              win_any;
    logic              xfer;
    logic              burst_end;

    assign cand    = ch_en & ch_ready;
    assign dmx_in  = in_data;
    assign dmx_sel = sel_q;

    rr_pick4 u_pick (
        .req       (cand),
        .ptr       (ptr),
        .grant_idx (win_idx),
        .any_grant (win_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ARB;
            ARB: begin
                if (!in_valid)    state_nxt = IDLE;
                else if (win_any) state_nxt = BURST;
            end
            BURST:   if (burst_end) state_nxt = ARB;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake is gated by rst_n so a beat on the reset edge is never taken.
    always_comb begin
        in_ready   = rst_n && (state == BURST) && ch_ready[sel_q];
        dmx_valid  = in_valid && in_ready;
        xfer       = dmx_valid;
        burst_end  = xfer && ((beat_cnt == CNT_LAST) || in_last);
        burst_done = burst_end;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr      <= '0;
            sel_q    <= '0;
            beat_cnt <= '0;
        end else begin
            if (state == ARB && in_valid && win_any) begin
                sel_q    <= win_idx;
                beat_cnt <= '0;
            end else if (burst_end) begin
                ptr      <= next_ptr(sel_q);
                beat_cnt <= '0;
            end else if (xfer) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/demux_dispatch.md
# demux_dispatch

Round-robin dispatcher that sits directly upstream of the 1-to-4 demultiplexer and drives its data input and 2-bit select. It accepts a single valid/ready input stream and carves it into bursts of up to BURST_LEN beats. Each burst goes to one of four output channels, chosen round-robin among channels that are enabled and ready. It owns all select sequencing, so the demux itself stays purely combinational.

## Interface
Parameters:
- DATA_W, default 1: width of the data beat passed to the demux input.
- BURST_LEN, default 4: maximum beats per burst; legal range 1..255.

Ports (clock and reset first; one clock, reset is synchronous and active-low):
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  beat accepted when in_valid & in_ready.
- in_data  input  DATA_W  upstream beat.
- in_last  input  1  marks the final beat of a packet; ends the burst early.
- ch_en  input  4  static per-channel enable mask.
- ch_ready  input  4  per-channel backpressure from the consumers behind the demux.
- dmx_in  output  DATA_W  data to the demux IN.
- dmx_sel  output  2  select to the demux SEL; registered.
- dmx_valid  output  1  qualifies dmx_in for the selected channel.
- burst_done  output  1  one-cycle pulse on the cycle the last beat of a burst transfers.

## Operation
- States: IDLE, ARB, BURST.
- IDLE:
  - in_ready=0.
  - Moves to ARB when in_valid=1.
- ARB:
  - Candidates are ch_en & ch_ready.
  - Picks the first candidate at or after index ptr, wrapping 3→0.
  - On a hit: dmx_sel←winner, beat_cnt←0, go to BURST.
  - No candidate: stay in ARB; dmx_sel is held.
- BURST:
  - in_ready = ch_ready[dmx_sel].
  - dmx_valid = in_valid & in_ready.
  - dmx_in = in_data (combinational pass-through).
  - Each transfer increments beat_cnt.
- End of burst: a transfer with beat_cnt==BURST_LEN-1 or in_last=1.
  - burst_done=1 for that cycle.
  - ptr←dmx_sel+1 (mod 4).
  - Next state is ARB if in_valid is still expected, otherwise IDLE. Concretely: go to ARB unconditionally, and ARB falls back to IDLE when in_valid=0.
- ARB with in_valid=0 → IDLE.
- in_last and beat-count limit on the same beat: a single burst end, a single burst_done pulse.
- ch_en is sampled only in ARB. Clearing an enable mid-burst does not abort the burst.
- ch_ready low mid-burst stalls the burst (in_ready=0) with no re-arbitration.
- beat_cnt width is clog2(BURST_LEN)+1 and never exceeds BURST_LEN-1.
- BURST_LEN=1: every beat is its own burst; channels rotate each accepted beat.

## Timing
- Reset values: state=IDLE, ptr=0, dmx_sel=2'b00, beat_cnt=0, in_ready=0, dmx_valid=0, burst_done=0.
  - dmx_in follows in_data but is unqualified during reset.
- Reset asserted mid-burst: the next edge returns to IDLE and the partial burst is dropped.
  - Any beat presented on the reset edge is not accepted.
- Data latency from in_data to dmx_in: 0 cycles.
- dmx_sel changes only on the ARB→BURST edge, so it is stable for the whole burst.
- Arbitration bubble: exactly one cycle (ARB) between bursts, during which in_ready=0.
- Steady-state throughput: BURST_LEN beats per BURST_LEN+1 cycles.
- IDLE→ARB→BURST: first beat accepted no earlier than cycle 2 after in_valid rises.

## Structure
- Shared package holds:
  - NUM_CH=4 and SEL_W=2.
  - State enum {IDLE, ARB, BURST}.
  - Function next_ptr(sel).
- One sub-module: rr_pick4.
  - Combinational round-robin picker.
  - Inputs: req[3:0] and ptr[1:0].
  - Outputs: grant_idx[1:0] and any_grant.
  - Reused by later arbiters in the design.

## Test plan
- Reset, then in_valid=1, ch_en=4'hF, ch_ready=4'hF, BURST_LEN=4, 16 beats → dmx_sel sequence 0,1,2,3, four beats each, one-cycle ARB gap, four burst_done pulses.
- ch_en=4'b1010, continuous traffic → dmx_sel alternates 1,3,1,3; channels 0 and 2 never selected.
- ch_ready[1] dropped for 3 cycles mid-burst on channel 1 → in_ready=0 and dmx_valid=0 for 3 cycles, beat_cnt held, burst resumes on channel 1, no beat lost or duplicated.
- in_last on beat 2 of a 4-beat burst → burst_done on beat 2, next burst goes to the next channel; in_last on beat 4 → exactly one pulse.
- ch_ready=0 during ARB for 5 cycles, then 4'b0100 → stays in ARB for 5 cycles with in_ready=0, then dmx_sel=2.
- rst_n=0 for one cycle mid-burst on channel 2 → next cycle state=IDLE, dmx_sel=0, ptr=0; the first post-reset burst goes to channel 0.
